// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
// Holds the FSM state encoding and the bus-level ACK/NACK bit values.
package i2c_pkg;

   localparam int I2C_ADDR_WIDTH = 7;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and decodes SCL edges plus
// START/STOP conditions as single-cycle pulses.
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_d;
   logic       sda_d;
   logic       scl_s;

   // NOTE: non-blocking assignments let each flop take the previous stage's
   // old value, which is what makes this a shift chain rather than a wire.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s    = scl_sync[1];
   assign sda_s    = sda_sync[1];
   assign scl_rise =  scl_s & ~scl_d;
   assign scl_fall = ~scl_s &  scl_d;
   // SCL must be steady high across the SDA transition to count as START/STOP.
   assign start    = scl_s & scl_d &  sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-wide register file: address match, pointer
// write, burst write and auto-incrementing burst read.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h50,
   parameter int                        DEPTH       = 16
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  logic                     SCL_IN,
   input  logic                     SDA_IN,
   output logic                     SDA_OE,
   output logic                     WR_STROBE,
   output logic [$clog2(DEPTH)-1:0] WR_ADDR,
   output logic [7:0]               WR_DATA,
   input  logic [$clog2(DEPTH)-1:0] HOST_RADDR,
   output logic [7:0]               HOST_RDATA,
   output logic                     BUSY
);

   localparam int AW = $clog2(DEPTH);

   state_t          state;
   state_t          state_nxt;
   logic [7:0]      shift;
   logic [7:0]      shift_in;
   logic [3:0]      bit_cnt;
   logic [AW-1:0]   ptr;
   logic            mack;
   logic [7:0]      regs [DEPTH];

   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;
   logic sda_s;
   logic byte_done;
   logic ack_done;

   i2c_line_sync u_line_sync (
      .clk      (ACLK),
      .rst_n    (ARESETn),
      .scl      (SCL_IN),
      .sda      (SDA_IN),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_s    (sda_s)
   );

   assign shift_in  = {shift[6:0], sda_s};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   // The 9th (ACK) clock ends on the fall after bit_cnt has reached 9.
   assign ack_done  = scl_fall && (bit_cnt == 4'd9);

   always_ff @(posedge ACLK) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: state_nxt defaults to the current state before the case so every
   // path assigns it and no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (stop) begin
         state_nxt = IDLE;
      end else if (start) begin
         state_nxt = ADDR;
      end else begin
         case (state)
            ADDR:      if (byte_done)
                          state_nxt = (shift_in[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK:  if (ack_done)  state_nxt = shift[0] ? RDATA : PTR;
            PTR:       if (byte_done) state_nxt = PTR_ACK;
            PTR_ACK:   if (ack_done)  state_nxt = WDATA;
            WDATA:     if (byte_done) state_nxt = WDATA_ACK;
            WDATA_ACK: if (ack_done)  state_nxt = WDATA;
            RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = RDATA_ACK;
            RDATA_ACK: if (ack_done)  state_nxt = (mack == ACK) ? RDATA : WAIT_STOP;
            default:   state_nxt = state;
         endcase
      end
   end

   always_comb begin
      BUSY = (state != IDLE);
   end

   // NOTE: the register array is cleared by reset because an all-zero map
   // after ARESETn is externally visible behaviour.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         shift     <= 8'h00;
         bit_cnt   <= 4'd0;
         ptr       <= '0;
         mack      <= NACK;
         SDA_OE    <= 1'b0;
         WR_STROBE <= 1'b0;
         WR_ADDR   <= '0;
         WR_DATA   <= 8'h00;
         for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
      end else begin
         WR_STROBE <= 1'b0;
         if (stop) begin
            SDA_OE <= 1'b0;
         end else if (start) begin
            SDA_OE  <= 1'b0;
            bit_cnt <= 4'd0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift   <= shift_in;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7 && state == PTR) ptr <= shift_in[AW-1:0];
                     if (bit_cnt == 4'd7 && state == WDATA) begin
                        regs[ptr] <= shift_in;
                        WR_STROBE <= 1'b1;
                        WR_ADDR   <= ptr;
                        WR_DATA   <= shift_in;
                        ptr       <= ptr + AW'(1);
                     end
                  end
               end
               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_rise && bit_cnt == 4'd8) bit_cnt <= 4'd9;
                  if (scl_fall && bit_cnt == 4'd8) SDA_OE <= 1'b1;
                  if (ack_done) begin
                     bit_cnt <= 4'd0;
                     SDA_OE  <= 1'b0;
                     if (state == ADDR_ACK && shift[0]) begin
                        shift  <= regs[ptr];
                        SDA_OE <= ~regs[ptr][7];
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        SDA_OE <= 1'b0;
                        ptr    <= ptr + AW'(1);
                     end else begin
                        shift  <= {shift[6:0], 1'b0};
                        SDA_OE <= ~shift[6];
                     end
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise && bit_cnt == 4'd8) begin
                     mack    <= sda_s;
                     bit_cnt <= 4'd9;
                  end
                  if (ack_done) begin
                     bit_cnt <= 4'd0;
                     if (mack == ACK) begin
                        shift  <= regs[ptr];
                        SDA_OE <= ~regs[ptr][7];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign HOST_RDATA = regs[HOST_RADDR];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives the
// open-drain bus and each scenario task checks its own results inline.
module tb_i2c_target_regfile;

   localparam int Q = 8;  // ACLK cycles per quarter SCL period

   logic       ACLK = 1'b0;
   logic       ARESETn;
   logic       scl;
   logic       m_sda;
   logic       sda_line;
   logic       SDA_OE;
   logic       WR_STROBE;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic [3:0] HOST_RADDR;
   logic [7:0] HOST_RDATA;
   logic       BUSY;

   int checks = 0;
   int errors = 0;

   logic [3:0] wa_q [$];
   logic [7:0] wd_q [$];
   int         oe_cnt = 0;

   always #5 ACLK = ~ACLK;

   assign sda_line = m_sda & ~SDA_OE;

   i2c_target_regfile #(.TARGET_ADDR(7'h50), .DEPTH(16)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .SCL_IN     (scl),
      .SDA_IN     (sda_line),
      .SDA_OE     (SDA_OE),
      .WR_STROBE  (WR_STROBE),
      .WR_ADDR    (WR_ADDR),
      .WR_DATA    (WR_DATA),
      .HOST_RADDR (HOST_RADDR),
      .HOST_RDATA (HOST_RDATA),
      .BUSY       (BUSY)
   );

   always @(negedge ACLK) begin
      if (WR_STROBE) begin
         wa_q.push_back(WR_ADDR);
         wd_q.push_back(WR_DATA);
      end
      if (SDA_OE) oe_cnt++;
   end

   initial begin
      repeat (80000) @(posedge ACLK);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1);
   end

   // ---------------- bus driver tasks ----------------
   task automatic hold(input int n);
      repeat (n * Q) @(negedge ACLK);
   endtask

   task automatic i2c_start;
      m_sda = 1'b1; hold(1);
      scl   = 1'b1; hold(1);
      m_sda = 1'b0; hold(1);
      scl   = 1'b0; hold(1);
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0; hold(1);
      scl   = 1'b1; hold(1);
      m_sda = 1'b1; hold(1);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         m_sda = b[i]; hold(1);
         scl   = 1'b1; hold(2);
         scl   = 1'b0; hold(1);
      end
   endtask

   task automatic get_ack(output logic a);
      m_sda = 1'b1; hold(1);
      scl   = 1'b1; hold(1);
      a     = sda_line; hold(1);
      scl   = 1'b0; hold(1);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      send_bits(b, 8);
      get_ack(a);
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] b);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         m_sda = 1'b1; hold(1);
         scl   = 1'b1; hold(1);
         v[i]  = sda_line; hold(1);
         scl   = 1'b0; hold(1);
      end
      m_sda = master_ack; hold(1);
      scl   = 1'b1; hold(2);
      scl   = 1'b0; hold(1);
      m_sda = 1'b1;
      b = v;
   endtask

   task automatic peek(input logic [3:0] a, output logic [7:0] d);
      HOST_RADDR = a;
      @(negedge ACLK);
      d = HOST_RDATA;
   endtask

   function automatic logic [11:0] strobe_at(input int idx);
      if (idx < wa_q.size()) return {wa_q[idx], wd_q[idx]};
      return 12'hFFF;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic [7:0] d;
      checks++; if (SDA_OE !== 1'b0)    begin errors++; $display("FAIL reset_sda_oe got %b want 0", SDA_OE); end
      checks++; if (WR_STROBE !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe got %b want 0", WR_STROBE); end
      checks++; if (WR_ADDR !== 4'h0)   begin errors++; $display("FAIL reset_wr_addr got %h want 0", WR_ADDR); end
      checks++; if (WR_DATA !== 8'h00)  begin errors++; $display("FAIL reset_wr_data got %h want 00", WR_DATA); end
      checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
      peek(4'd5, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg5 got %h want 00", d); end
   endtask

   task automatic test_write_burst;
      logic       a0, a1, a2, a3;
      logic [7:0] d;
      int         base;
      base = wa_q.size();
      i2c_start;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy_after_start got %b want 1", BUSY); end
      write_byte(8'hA0, a0);
      write_byte(8'h03, a1);
      write_byte(8'hA5, a2);
      write_byte(8'h5A, a3);
      i2c_stop;
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks got %b want 0000", {a0, a1, a2, a3}); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b want 0", BUSY); end
      checks++; if (wa_q.size() - base !== 2) begin errors++; $display("FAIL wr_strobe_count got %0d want 2", wa_q.size() - base); end
      checks++; if (strobe_at(base) !== 12'h3A5)     begin errors++; $display("FAIL wr_strobe0 got %h want 3a5", strobe_at(base)); end
      checks++; if (strobe_at(base + 1) !== 12'h45A) begin errors++; $display("FAIL wr_strobe1 got %h want 45a", strobe_at(base + 1)); end
      peek(4'd3, d);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wr_reg3 got %h want a5", d); end
      peek(4'd4, d);
      checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wr_reg4 got %h want 5a", d); end
   endtask

   task automatic test_read_rs;
      logic       a0, a1, a2;
      logic [7:0] b0, b1;
      int         base;
      base = wa_q.size();
      i2c_start;
      write_byte(8'hA0, a0);
      write_byte(8'h03, a1);
      i2c_start;
      write_byte(8'hA1, a2);
      read_byte(1'b0, b0);
      read_byte(1'b1, b1);
      checks++; if (SDA_OE !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack got %b want 0", SDA_OE); end
      checks++; if (BUSY !== 1'b1)   begin errors++; $display("FAIL rd_busy_wait_stop got %b want 1", BUSY); end
      i2c_stop;
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got %b want 000", {a0, a1, a2}); end
      checks++; if (b0 !== 8'hA5) begin errors++; $display("FAIL rd_byte0 got %h want a5", b0); end
      checks++; if (b1 !== 8'h5A) begin errors++; $display("FAIL rd_byte1 got %h want 5a", b1); end
      checks++; if (wa_q.size() !== base) begin errors++; $display("FAIL rd_no_write got %0d want %0d", wa_q.size(), base); end
   endtask

   task automatic test_addr_mismatch;
      logic a0, a1;
      int   base, oe_base;
      base    = wa_q.size();
      oe_base = oe_cnt;
      i2c_start;
      write_byte(8'hB0, a0);
      write_byte(8'h00, a1);
      i2c_stop;
      checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL mm_nacks got %b want 11", {a0, a1}); end
      checks++; if (oe_cnt !== oe_base) begin errors++; $display("FAIL mm_sda_oe_cycles got %0d want 0", oe_cnt - oe_base); end
      checks++; if (wa_q.size() !== base) begin errors++; $display("FAIL mm_no_write got %0d want %0d", wa_q.size(), base); end
   endtask

   task automatic test_ptr_wrap;
      logic       a0, a1, a2, a3;
      logic [7:0] d;
      int         base;
      base = wa_q.size();
      i2c_start;
      write_byte(8'hA0, a0);
      write_byte(8'h0F, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, a3);
      i2c_stop;
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks got %b want 0000", {a0, a1, a2, a3}); end
      checks++; if (strobe_at(base) !== 12'hF11)     begin errors++; $display("FAIL wrap_strobe0 got %h want f11", strobe_at(base)); end
      checks++; if (strobe_at(base + 1) !== 12'h022) begin errors++; $display("FAIL wrap_strobe1 got %h want 022", strobe_at(base + 1)); end
      peek(4'd15, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_reg15 got %h want 11", d); end
      peek(4'd0, d);
      checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_reg0 got %h want 22", d); end
   endtask

   task automatic test_stop_mid_byte;
      logic       a0, a1;
      logic [7:0] d;
      int         base;
      base = wa_q.size();
      i2c_start;
      write_byte(8'hA0, a0);
      write_byte(8'h02, a1);
      send_bits(8'hA0, 4);
      i2c_stop;
      checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mid_acks got %b want 00", {a0, a1}); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", BUSY); end
      checks++; if (wa_q.size() !== base) begin errors++; $display("FAIL mid_no_write got %0d want %0d", wa_q.size(), base); end
      peek(4'd2, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reg2 got %h want 00", d); end
   endtask

   task automatic test_reset_mid_ack;
      logic       a0, a1, a2, a3, a4, a5;
      logic [7:0] d, b0;
      int         base;
      i2c_start;
      send_bits(8'hA0, 8);
      checks++; if (SDA_OE !== 1'b1) begin errors++; $display("FAIL rst_ack_driven got %b want 1", SDA_OE); end
      ARESETn = 1'b0;
      @(negedge ACLK);
      checks++; if (SDA_OE !== 1'b0)    begin errors++; $display("FAIL rst_sda_oe got %b want 0", SDA_OE); end
      checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
      checks++; if (WR_STROBE !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe got %b want 0", WR_STROBE); end
      ARESETn = 1'b1;
      peek(4'd3, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg3 got %h want 00", d); end
      peek(4'd15, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg15 got %h want 00", d); end
      m_sda = 1'b1; hold(1);
      scl   = 1'b1; hold(2);
      scl   = 1'b0; hold(1);
      i2c_stop;
      base = wa_q.size();
      i2c_start;
      write_byte(8'hA0, a0);
      write_byte(8'h07, a1);
      write_byte(8'hC3, a2);
      i2c_stop;
      i2c_start;
      write_byte(8'hA0, a3);
      write_byte(8'h07, a4);
      i2c_start;
      write_byte(8'hA1, a5);
      read_byte(1'b1, b0);
      i2c_stop;
      checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b0) begin errors++; $display("FAIL post_rst_acks got %b want 000000", {a0, a1, a2, a3, a4, a5}); end
      checks++; if (strobe_at(base) !== 12'h7C3) begin errors++; $display("FAIL post_rst_strobe got %h want 7c3", strobe_at(base)); end
      checks++; if (b0 !== 8'hC3) begin errors++; $display("FAIL post_rst_readback got %h want c3", b0); end
   endtask

   initial begin
      ARESETn    = 1'b0;
      scl        = 1'b1;
      m_sda      = 1'b1;
      HOST_RADDR = 4'd0;
      repeat (4) @(negedge ACLK);
      ARESETn = 1'b1;
      repeat (4) @(negedge ACLK);
      test_reset;
      test_write_burst;
      test_read_rs;
      test_addr_mismatch;
      test_ptr_wrap;
      test_stop_mid_byte;
      test_reset_mid_ack;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
